// File: rtl/display_pkg.sv
// Shared constants, state type and BCD helper for the signed BCD display path.
package display_pkg;

  typedef enum logic {IDLE, CONVERT} state_t;

  // Active-low segment codes, bit order g..a.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Non-decimal code the encoder renders as a minus sign.
  localparam logic [3:0] BCD_MINUS = 4'hA;

  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/seg7_digit_enc.sv
// One 7-segment digit encoder: BCD 0..9, BCD_MINUS as '-', anything else or blank_i dark.
module seg7_digit_enc
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      if (bcd_i <= 4'd9)
        seg_o = SEG_DIGIT[bcd_i];
      else if (bcd_i == BCD_MINUS)
        seg_o = SEG_MINUS;
    end
  end

endmodule

// File: rtl/signed_bcd_display_seq.sv
// Iterative double-dabble signed value to sign + BCD + 7-segment display driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits above the ones digit).
module signed_bcd_display_seq
  import display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NDIG   = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  sign_out,
  output logic [4*NDIG-1:0]     bcd_out,
  output logic [7*(NDIG+1)-1:0] seg_out
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("signed_bcd_display_seq: WIDTH must be >= 2");
  end
  if ((64'(10) ** NDIG) <= ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_ndig
    $error("signed_bcd_display_seq: NDIG too small for WIDTH");
  end

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    sign_q;
  logic [4*NDIG-1:0]       scr_q, scr_adj, scr_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic                    in_neg;
  logic [NDIG-1:0]         lz_blank;
  logic [7*(NDIG+1)-1:0]   seg_d;
  logic                    out_valid_q, sign_out_q;
  logic [4*NDIG-1:0]       bcd_out_q;
  logic [7*(NDIG+1)-1:0]   seg_out_q;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CONVERT);

  // Two's-complement negate in WIDTH bits; the most negative value maps to 2**(WIDTH-1).
  assign in_neg = SIGNED && in_data[WIDTH-1];
  assign mag_d  = in_neg ? (~in_data + WIDTH'(1)) : in_data;

  always_comb begin
    scr_adj = '0;
    for (int i = 0; i < NDIG; i++)
      scr_adj[4*i +: 4] = bcd_add3(scr_q[4*i +: 4]);
  end

  // Scratch after this edge's add-3 and shift; on the last shift it is the final result.
  assign scr_d = {scr_adj[4*NDIG-2:0], mag_q[WIDTH-1]};

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin : lz_scan
    logic zero_above;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above  = zero_above && (scr_d[4*i +: 4] == 4'd0);
      lz_blank[i] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    seg7_digit_enc u_enc (
      .bcd_i   (scr_d[4*g +: 4]),
      .blank_i (lz_blank[g]),
      .seg_o   (seg_d[7*g +: 7])
    );
  end

  seg7_digit_enc u_sign_enc (
    .bcd_i   (BCD_MINUS),
    .blank_i (~sign_q),
    .seg_o   (seg_d[7*NDIG +: 7])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sign_out_q  <= 1'b0;
      bcd_out_q   <= '0;
      seg_out_q   <= '1;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= in_neg;
            cnt_q   <= CW'(WIDTH);
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b1;
            sign_out_q  <= sign_q;
            bcd_out_q   <= scr_d;
            seg_out_q   <= seg_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Shift register needs no reset: it is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      if (in_valid) begin
        scr_q <= '0;
        mag_q <= mag_d;
      end
    end else begin
      scr_q <= scr_d;
      mag_q <= {mag_q[WIDTH-2:0], 1'b0};
    end
  end

  assign out_valid = out_valid_q;
  assign sign_out  = sign_out_q;
  assign bcd_out   = bcd_out_q;
  assign seg_out   = seg_out_q;

endmodule
